conv2_feed_sched: RTL and testbench

// - Scheduler between pool1 and conv2. Sequences the per-row transfer of the two pool1 output vectors into conv2's input registers.
// - Counts slots within a fixed row period, loads each vector at its programmed slot, and issues one conv2 start pulse per completed row pair.
// - Stalls when conv2 is not ready. Signals frame completion after ROWS pairs.

---
 rtl/conv2_feed_sched_pkg.sv | 12 +
 rtl/conv2_feed_sched_if.sv | 31 +++
 rtl/conv2_feed_sched_slot_cnt.sv | 20 ++
 rtl/conv2_feed_sched.sv | 93 +++++++++
 tb/tb_conv2_feed_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2_feed_sched_pkg.sv
// Shared definitions for pool->conv feed schedulers.
// Holds the state encoding and the default row-period and slot constants.
package cnn_sched_pkg;
  localparam int DATA_W_DEF     = 224;
  localparam int PERIOD_DEF     = 26;
  localparam int LOAD0_SLOT_DEF = 2;
  localparam int LOAD1_SLOT_DEF = 14;
  localparam int ROWS_DEF       = 12;
  localparam int SLOT_W         = $clog2(PERIOD_DEF);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} sched_state_t;
endpackage

// File: rtl/conv2_feed_sched_if.sv
// pool1 -> conv2 feed bus. The overrun flag exists only when
// SCHED_OVERRUN_CHK_EN is defined.
interface conv2_feed_sched_if #(
  parameter int DATA_W = 224,
  parameter int ROWS   = 12
);
  logic                    start;
  logic                    pool1_valid;
  logic [DATA_W-1:0]       out_pool1_1;
  logic [DATA_W-1:0]       out_pool1_2;
  logic                    conv2_ready;
  logic [DATA_W-1:0]       in_conv2_1;
  logic [DATA_W-1:0]       in_conv2_2;
  logic                    conv2_go;
  logic                    busy;
  logic                    done;
  logic [$clog2(ROWS)-1:0] row_cnt;
`ifdef SCHED_OVERRUN_CHK_EN
  logic                    overrun;

  modport master (output start, pool1_valid, out_pool1_1, out_pool1_2, conv2_ready,
                  input  in_conv2_1, in_conv2_2, conv2_go, busy, done, row_cnt, overrun);
  modport slave  (input  start, pool1_valid, out_pool1_1, out_pool1_2, conv2_ready,
                  output in_conv2_1, in_conv2_2, conv2_go, busy, done, row_cnt, overrun);
`else
  modport master (output start, pool1_valid, out_pool1_1, out_pool1_2, conv2_ready,
                  input  in_conv2_1, in_conv2_2, conv2_go, busy, done, row_cnt);
  modport slave  (input  start, pool1_valid, out_pool1_1, out_pool1_2, conv2_ready,
                  output in_conv2_1, in_conv2_2, conv2_go, busy, done, row_cnt);
`endif
endinterface

// File: rtl/conv2_feed_sched_slot_cnt.sv
// Enable-gated modulo-PERIOD slot counter; hold freezes it, last flags slot PERIOD-1.
module conv2_slot_cnt #(
  parameter int PERIOD = 26,
  parameter int SW     = $clog2(PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          hold,
  output logic [SW-1:0] slot,
  output logic          last
);
  assign last = (slot == SW'(PERIOD-1));

  always_ff @(posedge clk) begin
    if (rst || clr)      slot <= '0;
    else if (en && !hold) slot <= last ? '0 : slot + SW'(1);
  end
endmodule

// File: rtl/conv2_feed_sched.sv
// Row-pair scheduler feeding pool1 vectors into conv2's input registers.
// Optional SCHED_OVERRUN_CHK_EN adds a sticky overrun flag for data dropped in STALL.
module conv2_feed_sched
  import cnn_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PERIOD     = PERIOD_DEF,
  parameter int LOAD0_SLOT = LOAD0_SLOT_DEF,
  parameter int LOAD1_SLOT = LOAD1_SLOT_DEF,
  parameter int ROWS       = ROWS_DEF
) (
  input logic               clk,
  input logic               rst,
  conv2_feed_sched_if.slave bus
);
  localparam int SW = $clog2(PERIOD);
  localparam int RW = $clog2(ROWS);
  localparam logic [SW-1:0] L0       = SW'(LOAD0_SLOT);
  localparam logic [SW-1:0] L1       = SW'(LOAD1_SLOT);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);

  sched_state_t      state, state_nxt;
  logic [SW-1:0]     slot;
  logic              last;
  logic              stepping, load_en, wrap;
  logic [RW-1:0]     row_cnt;
  logic [DATA_W-1:0] in1, in2;
  logic              go, done;

  // STALL only ever sits on the last slot, waiting for conv2_ready.
  assign stepping = (state == RUN && bus.pool1_valid) || state == STALL;
  assign load_en  = state == RUN && bus.pool1_valid;
  assign wrap     = stepping && last && bus.conv2_ready;

  conv2_slot_cnt #(.PERIOD(PERIOD), .SW(SW)) u_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (stepping),
    .hold (last && !bus.conv2_ready),
    .slot (slot),
    .last (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.start) state_nxt = RUN;
      RUN, STALL: begin
        if (wrap)                  state_nxt = (row_cnt == ROW_LAST) ? DONE : RUN;
        else if (stepping && last) state_nxt = STALL;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      in1     <= '0;
      in2     <= '0;
      go      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      go    <= wrap;
      done  <= (state == DONE);
      if (load_en && slot == L0) in1 <= bus.out_pool1_1;
      if (load_en && slot == L1) in2 <= bus.out_pool1_2;
      if (wrap) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
    end
  end

  assign bus.in_conv2_1 = in1;
  assign bus.in_conv2_2 = in2;
  assign bus.conv2_go   = go;
  assign bus.done       = done;
  assign bus.busy       = (state == RUN) || (state == STALL);
  assign bus.row_cnt    = row_cnt;

`ifdef SCHED_OVERRUN_CHK_EN
  logic overrun;

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && bus.start))  overrun <= 1'b0;
    else if (state == STALL && bus.pool1_valid) overrun <= 1'b1;
  end

  assign bus.overrun = overrun;
`endif
endmodule

// File: tb/tb_conv2_feed_sched.sv
// Randomized bench for conv2_feed_sched against a slot/row behavioural model.
module tb_conv2_feed_sched;
  localparam int DW = 224, ROWS = 12, PER = 26, LD0 = 2, LD1 = 14;
  localparam int RW = $clog2(ROWS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2_feed_sched_if #(.DATA_W(DW), .ROWS(ROWS)) sif ();
  conv2_feed_sched dut (.clk(clk), .rst(rst), .bus(sif.slave));

  int errors = 0, checks = 0, k = 0;

  // model: m_run = RUN or STALL, m_fin = in the one-cycle DONE state
  bit          m_run, m_stall, m_fin, m_go, m_done, m_ovr;
  int          m_slot, m_row;
  logic [DW-1:0] m_in1, m_in2;

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_step();
    bit acc, fin_now;
    if (rst) begin
      m_run = 0; m_stall = 0; m_fin = 0; m_go = 0; m_done = 0; m_ovr = 0;
      m_slot = 0; m_row = 0; m_in1 = '0; m_in2 = '0;
      return;
    end
    fin_now = m_fin;
    m_done = m_fin; m_fin = 0; m_go = 0;
    if (!m_run) begin
      if (!fin_now && sif.start) begin m_run = 1; m_ovr = 0; end
    end else begin
      if (m_stall && sif.pool1_valid) m_ovr = 1;
      acc = m_stall || sif.pool1_valid;
      if (acc) begin
        if (!m_stall && m_slot == LD0) m_in1 = sif.out_pool1_1;
        if (!m_stall && m_slot == LD1) m_in2 = sif.out_pool1_2;
        if (m_slot < PER-1) m_slot++;
        else if (sif.conv2_ready) begin
          m_go = 1; m_slot = 0; m_stall = 0;
          if (m_row == ROWS-1) begin m_row = 0; m_run = 0; m_fin = 1; end
          else m_row++;
        end else m_stall = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    sif.out_pool1_1 = rnd_vec();
    sif.out_pool1_2 = rnd_vec();
    k++;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic do_start();
    sif.start = 1; tick(); sif.start = 0; k = 0;
  endtask

  task automatic test_reset();
    rst = 1; sif.start = 1; sif.pool1_valid = 1; sif.conv2_ready = 1;
    tick(); tick();
    checks++;
    if ({sif.conv2_go, sif.busy, sif.done, sif.row_cnt} !== '0) begin
      errors++; $display("FAIL reset_ctl got go/busy/done/row=%b/%b/%b/%0d want 0", sif.conv2_go, sif.busy, sif.done, sif.row_cnt);
    end
    checks++;
    if (sif.in_conv2_1 !== '0 || sif.in_conv2_2 !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0", sif.in_conv2_1, sif.in_conv2_2);
    end
    rst = 0; sif.start = 0; tick();
    checks++;
    if (sif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored busy got %b want 0", sif.busy);
    end
  endtask

  task automatic test_stream();
    int go_cnt = 0, first_go = -1, last_go = -1, done_k = -1;
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < PER*ROWS + 10) begin
      checks++;
      if ({sif.conv2_go, sif.busy, sif.done, sif.row_cnt} !== {m_go, m_run, m_done, RW'(m_row)}) begin
        errors++; $display("FAIL stream_ctl k=%0d got go/busy/done/row=%b/%b/%b/%0d want %b/%b/%b/%0d",
          k, sif.conv2_go, sif.busy, sif.done, sif.row_cnt, m_go, m_run, m_done, m_row);
      end
      checks++;
      if (sif.in_conv2_1 !== m_in1 || sif.in_conv2_2 !== m_in2) begin
        errors++; $display("FAIL stream_data k=%0d got %h/%h want %h/%h", k, sif.in_conv2_1, sif.in_conv2_2, m_in1, m_in2);
      end
      if (sif.conv2_go === 1'b1) begin
        if (last_go >= 0) begin
          checks++;
          if (k - last_go != PER) begin errors++; $display("FAIL stream_go_interval got %0d want %0d", k - last_go, PER); end
        end
        if (first_go < 0) first_go = k;
        last_go = k; go_cnt++;
      end
      if (sif.done === 1'b1) done_k = k;
      tick();
    end
    checks++;
    if (first_go != PER) begin errors++; $display("FAIL stream_first_go got k=%0d want k=%0d", first_go, PER); end
    checks++;
    if (go_cnt != ROWS) begin errors++; $display("FAIL stream_go_count got %0d want %0d", go_cnt, ROWS); end
    checks++;
    if (done_k != last_go + 1) begin errors++; $display("FAIL stream_done_time got k=%0d want k=%0d", done_k, last_go + 1); end
  endtask

  task automatic test_bubble();
    int go_k = -1, cap_k = -1;
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < 60 && go_k < 0) begin
      checks++;
      if ({sif.conv2_go, sif.busy, sif.row_cnt} !== {m_go, m_run, RW'(m_row)}) begin
        errors++; $display("FAIL bubble_ctl k=%0d got go/busy/row=%b/%b/%0d want %b/%b/%0d",
          k, sif.conv2_go, sif.busy, sif.row_cnt, m_go, m_run, m_row);
      end
      checks++;
      if (sif.in_conv2_1 !== m_in1 || sif.in_conv2_2 !== m_in2) begin
        errors++; $display("FAIL bubble_data k=%0d got %h/%h want %h/%h", k, sif.in_conv2_1, sif.in_conv2_2, m_in1, m_in2);
      end
      if (cap_k < 0 && sif.in_conv2_2 !== '0) cap_k = k;
      if (sif.conv2_go === 1'b1) go_k = k;
      sif.pool1_valid = !(k >= 4 && k <= 6);
      tick();
    end
    checks++;
    if (cap_k != LD1 + 1 + 3) begin errors++; $display("FAIL bubble_load1_time got k=%0d want k=%0d", cap_k, LD1 + 4); end
    checks++;
    if (go_k != PER + 3) begin errors++; $display("FAIL bubble_go_time got k=%0d want k=%0d", go_k, PER + 3); end
    sif.pool1_valid = 1;
  endtask

  task automatic test_stall();
    int go1 = -1, go2 = -1;
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < 100 && go2 < 0) begin
      checks++;
      if ({sif.conv2_go, sif.busy, sif.row_cnt} !== {m_go, m_run, RW'(m_row)}) begin
        errors++; $display("FAIL stall_ctl k=%0d got go/busy/row=%b/%b/%0d want %b/%b/%0d",
          k, sif.conv2_go, sif.busy, sif.row_cnt, m_go, m_run, m_row);
      end
      if (k >= 26 && k <= 35) begin
        checks++;
        if (sif.busy !== 1'b1 || sif.conv2_go !== 1'b0) begin
          errors++; $display("FAIL stall_hold k=%0d got busy/go=%b/%b want 1/0", k, sif.busy, sif.conv2_go);
        end
      end
`ifdef SCHED_OVERRUN_CHK_EN
      checks++;
      if (sif.overrun !== m_ovr) begin errors++; $display("FAIL stall_overrun k=%0d got %b want %b", k, sif.overrun, m_ovr); end
`endif
      if (sif.conv2_go === 1'b1) begin if (go1 < 0) go1 = k; else go2 = k; end
      sif.conv2_ready = !(k >= 25 && k <= 34);
      tick();
    end
    checks++;
    if (go1 != 36) begin errors++; $display("FAIL stall_go_time got k=%0d want k=36", go1); end
    checks++;
    if (go2 != 36 + PER) begin errors++; $display("FAIL stall_slot_restart got k=%0d want k=%0d", go2, 36 + PER); end
    sif.conv2_ready = 1;
  endtask

  task automatic test_midreset();
    int go_cnt = 0, done_cnt = 0;
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < 4*PER + 9) tick();
    checks++;
    if (sif.row_cnt !== RW'(4)) begin errors++; $display("FAIL midreset_row got %0d want 4", sif.row_cnt); end
    rst = 1; tick(); rst = 0;
    checks++;
    if ({sif.conv2_go, sif.busy, sif.done, sif.row_cnt} !== '0 || sif.in_conv2_1 !== '0 || sif.in_conv2_2 !== '0) begin
      errors++; $display("FAIL midreset_clear got go/busy/done/row=%b/%b/%b/%0d in1/in2 nonzero=%b/%b want all 0",
        sif.conv2_go, sif.busy, sif.done, sif.row_cnt, |sif.in_conv2_1, |sif.in_conv2_2);
    end
    do_start();
    while (k < PER*ROWS + 5) begin
      checks++;
      if ({sif.conv2_go, sif.busy, sif.done, sif.row_cnt} !== {m_go, m_run, m_done, RW'(m_row)}) begin
        errors++; $display("FAIL midreset_ctl k=%0d got go/busy/done/row=%b/%b/%b/%0d want %b/%b/%b/%0d",
          k, sif.conv2_go, sif.busy, sif.done, sif.row_cnt, m_go, m_run, m_done, m_row);
      end
      go_cnt += int'(sif.conv2_go === 1'b1);
      done_cnt += int'(sif.done === 1'b1);
      tick();
    end
    checks++;
    if (go_cnt != ROWS || done_cnt != 1) begin
      errors++; $display("FAIL midreset_frame got go=%0d done=%0d want %0d/1", go_cnt, done_cnt, ROWS);
    end
  endtask

  task automatic test_start_ignored();
    int go_cnt = 0, first_go = -1;
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < 60) begin
      checks++;
      if ({sif.conv2_go, sif.busy, sif.row_cnt} !== {m_go, m_run, RW'(m_row)}) begin
        errors++; $display("FAIL start_ign_ctl k=%0d got go/busy/row=%b/%b/%0d want %b/%b/%0d",
          k, sif.conv2_go, sif.busy, sif.row_cnt, m_go, m_run, m_row);
      end
      if (sif.conv2_go === 1'b1) begin go_cnt++; if (first_go < 0) first_go = k; end
      sif.start = ($urandom_range(0, 3) == 0);
      tick();
    end
    sif.start = 0;
    checks++;
    if (first_go != PER || go_cnt != 2 || sif.row_cnt !== RW'(2)) begin
      errors++; $display("FAIL start_ign_timing got first_go=%0d gos=%0d row=%0d want %0d/2/2", first_go, go_cnt, sif.row_cnt, PER);
    end
  endtask

`ifdef SCHED_OVERRUN_CHK_EN
  task automatic test_overrun();
    do_reset(); sif.pool1_valid = 1; sif.conv2_ready = 1; do_start();
    while (k < PER*ROWS + 20) begin
      sif.conv2_ready = !(k >= 25 && k <= 27);
      sif.start = (k == 40);
      tick();
    end
    checks++;
    if (sif.overrun !== 1'b1 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL overrun_sticky got overrun/busy=%b/%b want 1/0", sif.overrun, sif.busy);
    end
    sif.start = 1; tick(); sif.start = 0;
    checks++;
    if (sif.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", sif.overrun); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 499) == 0);
      sif.start       = ($urandom_range(0, 19) == 0);
      sif.pool1_valid = ($urandom_range(0, 3) != 0);
      sif.conv2_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({sif.conv2_go, sif.busy, sif.done, sif.row_cnt} !== {m_go, m_run, m_done, RW'(m_row)}) begin
        errors++; $display("FAIL random_ctl n=%0d got go/busy/done/row=%b/%b/%b/%0d want %b/%b/%b/%0d",
          n, sif.conv2_go, sif.busy, sif.done, sif.row_cnt, m_go, m_run, m_done, m_row);
      end
      checks++;
      if (sif.in_conv2_1 !== m_in1 || sif.in_conv2_2 !== m_in2) begin
        errors++; $display("FAIL random_data n=%0d got %h/%h want %h/%h", n, sif.in_conv2_1, sif.in_conv2_2, m_in1, m_in2);
      end
`ifdef SCHED_OVERRUN_CHK_EN
      checks++;
      if (sif.overrun !== m_ovr) begin errors++; $display("FAIL random_overrun n=%0d got %b want %b", n, sif.overrun, m_ovr); end
`endif
    end
    rst = 0; sif.start = 0;
  endtask

  initial begin
    rst = 1; sif.start = 0; sif.pool1_valid = 0; sif.conv2_ready = 1;
    sif.out_pool1_1 = rnd_vec(); sif.out_pool1_2 = rnd_vec();
    test_reset();
    test_stream();
    test_bubble();
    test_stall();
    test_midreset();
    test_start_ignored();
`ifdef SCHED_OVERRUN_CHK_EN
    test_overrun();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
